// File: rtl/playfield_renderer_if.sv
// Pixel-stream, grid-RAM and line-clear signals shared by the playfield renderer and its driver.
// The renderer takes the slave modport; the pixel source / RAM / game logic side takes master.
interface playfield_renderer_if #(
  parameter int COLS = 10,
  parameter int ROWS = 20
);
  localparam int ADDR_W = $clog2(ROWS * COLS);

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              pix_valid;
  logic              frame_start;
  logic [ADDR_W-1:0] cell_addr;
  logic [2:0]        cell_data;
  logic              clear_req;
  logic [ROWS-1:0]   clear_mask;
  logic              clear_done;
  logic [3:0]        Red;
  logic [3:0]        Green;
  logic [3:0]        Blue;
  logic              out_valid;

  modport master (
    output DrawX, DrawY, pix_valid, frame_start, cell_data, clear_req, clear_mask,
    input  cell_addr, clear_done, Red, Green, Blue, out_valid
  );

  modport slave (
    input  DrawX, DrawY, pix_valid, frame_start, cell_data, clear_req, clear_mask,
    output cell_addr, clear_done, Red, Green, Blue, out_valid
  );
endinterface

// File: rtl/playfield_renderer.sv
// Three-stage playfield pixel renderer: coordinate decode, grid-RAM read, palette/priority colour.
// Define PLAYFIELD_FLASH_EN to build the line-clear flash FSM; otherwise clear_done is tied low.
module playfield_renderer #(
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int CELL         = 24,
  parameter int ORIGIN_X     = 100,
  parameter int ORIGIN_Y     = 0,
  parameter int FLASH_FRAMES = 16
) (
  input logic             Clk,
  input logic             Reset,
  playfield_renderer_if.slave bus
);
  localparam int FIELD_W = COLS * CELL;
  localparam int FIELD_H = ROWS * CELL;
  localparam int ADDR_W  = $clog2(ROWS * COLS);

  function automatic logic [11:0] palette(input logic [2:0] code);
    case (code)
      3'd0: return 12'h007;
      3'd1: return 12'h0FF;
      3'd2: return 12'hFF0;
      3'd3: return 12'hA0F;
      3'd4: return 12'h0F0;
      3'd5: return 12'hF00;
      3'd6: return 12'h00F;
      3'd7: return 12'hF80;
    endcase
  endfunction

  // Signed offsets so pixels left of / above the origin stay outside instead of wrapping.
  int                dx;
  int                dy;
  logic              in_field;
  logic              grid;
  logic              outline;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    dx        = int'(bus.DrawX) - ORIGIN_X;
    dy        = int'(bus.DrawY) - ORIGIN_Y;
    in_field  = (dx >= 0) && (dx < FIELD_W) && (dy >= 0) && (dy < FIELD_H);
    grid      = ((dx % CELL) == 0) || ((dy % CELL) == 0);
    outline   = (((dx == -1) || (dx == FIELD_W)) && (dy >= 0) && (dy <= FIELD_H)) ||
                ((dy == FIELD_H) && (dx >= -1) && (dx <= FIELD_W));
    addr_next = ADDR_W'((dy / CELL) * COLS + (dx / CELL));
  end

  logic s1_valid, s1_in_field, s1_grid, s1_outline;
  logic s2_valid, s2_in_field, s2_grid, s2_outline;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      bus.cell_addr <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      s2_valid <= s1_valid;
      if (bus.pix_valid && in_field) bus.cell_addr <= addr_next;
    end
  end

  // NOTE: per-pixel flags carry no reset; the reset valid bits make stale contents harmless.
  always_ff @(posedge Clk) begin
    s1_in_field <= in_field;
    s1_grid     <= grid;
    s1_outline  <= outline;
    s2_in_field <= s1_in_field;
    s2_grid     <= s1_grid;
    s2_outline  <= s1_outline;
  end

  logic flash_hit;

`ifdef PLAYFIELD_FLASH_EN
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, ARM, FLASH, DONE} flash_state_t;

  flash_state_t     state;
  logic [ROWS-1:0]  mask;
  logic [CNT_W-1:0] count;
  logic             phase;
  logic             clear_done_r;
  logic [ROW_W-1:0] s1_row, s2_row;

  always_ff @(posedge Clk) begin
    s1_row <= ROW_W'(dy / CELL);
    s2_row <= s1_row;
  end

  // phase is only written on frame_start, so the override never changes mid-frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      mask         <= '0;
      count        <= '0;
      phase        <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      clear_done_r <= 1'b0;
      case (state)
        IDLE: if (bus.clear_req) begin
          mask  <= bus.clear_mask;
          state <= ARM;
        end
        ARM: if (bus.frame_start) begin
          state <= FLASH;
          count <= '0;
          phase <= 1'b1;
        end
        FLASH: if (bus.frame_start) begin
          count <= count + 1'b1;
          if (count == CNT_W'(FLASH_FRAMES - 1)) begin
            state        <= DONE;
            phase        <= 1'b0;
            clear_done_r <= 1'b1;
          end else if (count[0]) begin
            phase <= ~phase;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  assign flash_hit      = phase && mask[s2_row];
  assign bus.clear_done = clear_done_r;
`else
  localparam int unused_flash_frames = FLASH_FRAMES;
  logic unused_flash_inputs;

  assign unused_flash_inputs = ^{bus.frame_start, bus.clear_req, bus.clear_mask};
  assign flash_hit           = 1'b0;
  assign bus.clear_done      = 1'b0;
`endif

  logic [11:0] rgb_next;

  always_comb begin
    if (s2_in_field && s2_grid)        rgb_next = 12'h02F;
    else if (s2_in_field && flash_hit) rgb_next = 12'hFFF;
    else if (s2_in_field)              rgb_next = palette(bus.cell_data);
    else if (s2_outline)               rgb_next = 12'h08F;
    else                               rgb_next = 12'h104;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.out_valid                   <= 1'b0;
      {bus.Red, bus.Green, bus.Blue}  <= 12'h000;
    end else begin
      bus.out_valid <= s2_valid;
      if (s2_valid) {bus.Red, bus.Green, bus.Blue} <= rgb_next;
    end
  end
endmodule

// File: tb/tb_playfield_renderer.sv
// Self-checking bench for playfield_renderer: directed pixels, gapped row stream, random frames,
// line-clear flash and mid-flash reset, against a frame-level reference model.
module tb_playfield_renderer;
  localparam int COLS = 10, ROWS = 20, CELL = 24, OX = 100, OY = 0, FLASH_FRAMES = 16;
  localparam int W = COLS * CELL, H = ROWS * CELL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  playfield_renderer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  playfield_renderer #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .Clk  (clk),
    .Reset(reset),
    .bus  (bus)
  );

  // Grid RAM with one-cycle registered read.
  logic [2:0] mem [ROWS*COLS];
  always @(posedge clk) bus.cell_data <= mem[bus.cell_addr];

  typedef struct { bit v; logic [11:0] rgb; } exp_t;
  exp_t hist[$];

  int tests = 0, failed = 0, done_seen = 0;
  int m_addr = 0;
  int m_frame = 0;
  bit m_armed = 0;
  logic [ROWS-1:0] m_mask = '0;
  logic [11:0] pal [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_field(input int x, input int y);
    return (x >= OX) && (x < OX + W) && (y >= OY) && (y < OY + H);
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y, input bit white);
    int fx = x - OX;
    int fy = y - OY;
    if (in_field(x, y)) begin
      if ((fx % CELL == 0) || (fy % CELL == 0)) return 12'h02F;
      if (white && m_mask[fy / CELL])           return 12'hFFF;
      return pal[mem[(fy / CELL) * COLS + fx / CELL]];
    end
    if ((x == OX - 1 || x == OX + W) && y >= OY && y <= OY + H) return 12'h08F;
    if (y == OY + H && x >= OX - 1 && x <= OX + W)              return 12'h08F;
    return 12'h104;
  endfunction

  task automatic tick(input bit v, input int x, input int y, input bit fs,
                      input bit req, input logic [ROWS-1:0] mask);
    exp_t e;
    bit   white;
    bit   exp_done = 1'b0;
    bus.pix_valid   = v;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.frame_start = fs;
    bus.clear_req   = req;
    bus.clear_mask  = mask;
`ifdef PLAYFIELD_FLASH_EN
    if (fs) begin
      if (m_armed) begin
        m_armed = 1'b0;
        m_frame = 1;
      end else if (m_frame > 0) begin
        m_frame++;
        if (m_frame > FLASH_FRAMES) begin
          m_frame  = 0;
          exp_done = 1'b1;
        end
      end
    end
    if (req && !m_armed && m_frame == 0 && !exp_done) begin
      m_mask  = mask;
      m_armed = 1'b1;
    end
`endif
    // Flash frames 1-2 lit, 3-4 dark, 5-6 lit, ...
    white = (m_frame > 0) && (((m_frame - 1) / 2) % 2 == 0);
    e.v   = v;
    e.rgb = model_rgb(x, y, white);
    if (v && in_field(x, y)) m_addr = ((y - OY) / CELL) * COLS + (x - OX) / CELL;
    hist.push_back(e);
    @(posedge clk);
    #1;
    if (bus.clear_done) done_seen++;
    check("cell_addr", 32'(bus.cell_addr), 32'(m_addr));
    check("clear_done", 32'(bus.clear_done), 32'(exp_done));
    if (hist.size() == 3) begin
      e = hist.pop_front();
      check("out_valid", 32'(bus.out_valid), 32'(e.v));
      if (e.v) check("rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'(e.rgb));
    end else begin
      check("out_valid_fill", 32'(bus.out_valid), 32'd0);
    end
  endtask

  task automatic pix(input int x, input int y);
    tick(1'b1, x, y, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic fstart();
    tick(1'b0, 0, 0, 1'b1, 1'b0, '0);
  endtask

  task automatic request(input logic [ROWS-1:0] mask);
    tick(1'b0, 0, 0, 1'b0, 1'b1, mask);
  endtask

  task automatic rand_pixels(input int n, input bit favor_bottom);
    for (int i = 0; i < n; i++) begin
      int x, y;
      bit v;
      v = ($urandom_range(0, 3) != 0);
      x = int'($urandom_range(80, 360));
      if (favor_bottom && $urandom_range(0, 1) == 1) y = int'($urandom_range(456, 481));
      else                                            y = int'($urandom_range(0, 490));
      tick(v, x, y, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic rand_frame(input int n, input bit favor_bottom);
    fstart();
    rand_pixels(n, favor_bottom);
    idle(3);
  endtask

  task automatic reset_ticks(input int n);
    reset = 1'b1;
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.clear_req   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_cell_addr", 32'(bus.cell_addr), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'd0);
      check("rst_clear_done", 32'(bus.clear_done), 32'd0);
    end
    hist.delete();
    m_addr  = 0;
    m_frame = 0;
    m_armed = 1'b0;
    reset   = 1'b0;
  endtask

  initial begin
    int x;
    int expected_done;
    pal = '{12'h007, 12'h0FF, 12'hFF0, 12'hA0F, 12'h0F0, 12'hF00, 12'h00F, 12'hF80};
    foreach (mem[i]) mem[i] = 3'($urandom);
    mem[0] = 3'd5;
    bus.DrawX = '0;
    bus.DrawY = '0;
    bus.clear_mask = '0;

    reset_ticks(2);
    idle(1);

    // Cell (0,0) palette colour, then grid line, outline, background, left-of-field hold.
    pix(101, 1);
    idle(3);
    pix(124, 30);
    pix(99, 30);
    pix(50, 30);
    pix(90, 30);
    idle(3);

    // Bottom row stream with every third strobe dropped.
    x = 100;
    for (int i = 0; x <= 339; i++) begin
      if (i % 3 == 2) idle(1);
      else begin
        pix(x, 475);
        x++;
      end
    end
    idle(3);

    repeat (3) rand_frame(50, 1'b0);

    // Flash of row 19 across 18 frames; a second request mid-flash must be ignored.
    request(20'h80000);
    idle(1);
    for (int f = 1; f <= 18; f++) begin
      rand_frame(40, 1'b1);
      if (f == 8) begin
        request(20'hFFFFF);
        idle(1);
      end
    end
`ifdef PLAYFIELD_FLASH_EN
    expected_done = 1;
`else
    expected_done = 0;
`endif
    check("done_pulses_flash", 32'(done_seen), 32'(expected_done));

    // Reset during flash frame 5 aborts it; following frames show palette colours.
    request(20'h80000);
    idle(1);
    for (int f = 1; f <= 4; f++) rand_frame(30, 1'b1);
    fstart();
    rand_pixels(10, 1'b1);
    reset_ticks(2);
    idle(1);
    rand_frame(40, 1'b1);
    rand_frame(40, 1'b1);
    check("done_pulses_total", 32'(done_seen), 32'(expected_done));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/playfield_renderer.md
PLAYFIELD_RENDERER -- requirements
Module: playfield_renderer

Interface
REQ-001 Parameter COLS, default 10, number of playfield columns.
REQ-002 Parameter ROWS, default 20, number of playfield rows.
REQ-003 Parameter CELL, default 24, cell edge in pixels.
REQ-004 Parameter ORIGIN_X, default 100; ORIGIN_Y, default 0; top-left pixel of the field.
REQ-005 Parameter FLASH_FRAMES, default 16, length of the line-clear flash in frames (even, >=2).
REQ-006 Clk  in  1  system clock; the only clock.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 DrawX, DrawY  in  10 each  pixel coordinate, qualified by pix_valid.
REQ-009 pix_valid  in  1  pixel strobe; one pixel per asserted cycle.
REQ-010 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-011 cell_addr  out  $clog2(ROWS*COLS)  grid RAM read address, row*COLS+col.
REQ-012 cell_data  in  3  grid RAM data, valid exactly one cycle after cell_addr.
REQ-013 clear_req  in  1  request to flash the rows in clear_mask.
REQ-014 clear_mask  in  ROWS  rows to flash; bit r is row r.
REQ-015 clear_done  out  1  one-cycle pulse when the flash ends.
REQ-016 Red, Green, Blue  out  4 each  pixel colour; out_valid  out  1  colour qualifier.

Function
REQ-017 Latency SHALL be exactly 3 cycles: a pixel on pix_valid at cycle N drives out_valid with its colour at cycle N+3; gaps in pix_valid propagate unchanged.
REQ-018 Stage 1 SHALL register col=(DrawX-ORIGIN_X)/CELL, row=(DrawY-ORIGIN_Y)/CELL, the in-field flag, the grid-line flag (either offset mod CELL == 0) and the outline flag, and drive cell_addr.
REQ-019 cell_addr SHALL hold its previous value when the pixel is outside the field.
REQ-020 Stage 2 SHALL capture cell_data and map it through the palette: 0 -> 0,0,7; 1 -> 0,F,F; 2 -> F,F,0; 3 -> A,0,F; 4 -> 0,F,0; 5 -> F,0,0; 6 -> 0,0,F; 7 -> F,8,0.
REQ-021 Priority, highest first: grid line in field -> 0,2,F; flash override (REQ-025); cell palette; outline (DrawX == ORIGIN_X-1 or ORIGIN_X+COLS*CELL, or DrawY == ORIGIN_Y+ROWS*CELL, within field span) -> 0,8,F; otherwise background -> 1,0,4.
REQ-022 Coordinates left of or above the origin SHALL be out of field and SHALL NOT wrap into it through unsigned subtraction.
REQ-023 The flash FSM SHALL have the states IDLE, ARM, FLASH and DONE.
REQ-024 IDLE -> ARM when clear_req=1, latching clear_mask; ARM -> FLASH on the next frame_start, with the frame count at 0 and phase 1; clear_req in any state other than IDLE SHALL be ignored.
REQ-025 In FLASH, cells in latched rows SHALL render F,F,F while phase=1; grid lines still take priority.
REQ-026 In FLASH, each frame_start SHALL increment the frame count, and phase SHALL toggle every 2 frames.
REQ-027 FLASH -> DONE when the count reaches FLASH_FRAMES; DONE SHALL assert clear_done for one cycle, then go to IDLE.
REQ-028 A mask change during ARM or FLASH SHALL have no effect; the flash override SHALL take effect only at a frame_start boundary, never mid-frame.

Reset
REQ-029 Reset SHALL clear the pipeline valid bits, out_valid, clear_done, cell_addr and the frame count to 0, put the FSM in IDLE, and drive Red, Green, Blue to 0.
REQ-030 Reset asserted mid-flash SHALL abort the flash with no clear_done pulse; pixels in flight SHALL be discarded.

Configuration
REQ-031 With PLAYFIELD_FLASH_EN defined, the flash FSM, clear_req, clear_mask and clear_done SHALL be implemented as specified.
REQ-032 Without PLAYFIELD_FLASH_EN, the ports SHALL remain, clear_req and clear_mask SHALL be ignored, clear_done SHALL be tied to 0, no flash logic SHALL exist, and latency SHALL be unchanged.

Verification
REQ-033 Defaults; DrawX=101, DrawY=1, cell_data=5 -> cell_addr=0, and Red,Green,Blue = F,0,0 with out_valid exactly 3 cycles later.
REQ-034 DrawX=124, DrawY=30 -> 0,2,F (grid line); DrawX=99 -> 0,8,F; DrawX=50 -> 1,0,4; DrawX=90 -> 1,0,4 with cell_addr unchanged.
REQ-035 Stream DrawX 100..339 on row 475 with pix_valid gapped every 3rd cycle -> out_valid mirrors the gaps delayed by 3 cycles, and cell_addr steps 190..199.
REQ-036 PLAYFIELD_FLASH_EN defined; clear_mask=20'h80000, clear_req pulse, then 18 frame_starts -> row 19 is white in frames 1-2, 5-6, ... (phase 1), and clear_done pulses exactly once after the 16th frame.
REQ-037 Reset asserted in frame 5 of a flash -> FSM returns to IDLE, no clear_done, and the next frame renders palette colours.
REQ-038 PLAYFIELD_FLASH_EN undefined; the REQ-036 stimulus -> no white cells and clear_done stays 0.
